// File: rtl/jtag_tap_param.sv
// Parametrised JTAG TAP controller. TCK/TMS/TDI are oversampled on clk, so the FSM,
// IR and data registers all live in the single clk domain.
module jtag_tap_param #(
  parameter int unsigned IR_LEN      = 4,
  parameter int unsigned DR_WIDTH    = 8,
  parameter logic [31:0] IDCODE_VAL  = 32'h1000_563F,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tck,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_oe,
  output logic [DR_WIDTH-1:0] user_dr,
  input  logic [DR_WIDTH-1:0] user_dr_in,
  output logic                update_pulse,
  output logic [3:0]          tap_state
);

  localparam int unsigned ID_W = 32;
  localparam logic [IR_LEN-1:0] IR_IDCODE = IR_LEN'(1);
  localparam logic [IR_LEN-1:0] IR_USER   = IR_LEN'(2);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
    SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] tck_sync, tms_sync, tdi_sync;
  logic                   tck_prev;
  logic                   tck_s, tms_s, tdi_s, rise, fall;

  logic [IR_LEN-1:0]   ir_q, ir_sr;
  logic                bypass_sr;
  logic [ID_W-1:0]     idcode_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic                sel_user, sel_idcode, dr_bit0;

  // Pin synchronisers plus one extra tck flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tck_sync <= '0;
      tms_sync <= '0;
      tdi_sync <= '0;
      tck_prev <= 1'b0;
    end else begin
      tck_sync <= {tck_sync[SYNC_STAGES-2:0], tck};
      tms_sync <= {tms_sync[SYNC_STAGES-2:0], tms};
      tdi_sync <= {tdi_sync[SYNC_STAGES-2:0], tdi};
      tck_prev <= tck_s;
    end
  end

  assign tck_s = tck_sync[SYNC_STAGES-1];
  assign tms_s = tms_sync[SYNC_STAGES-1];
  assign tdi_s = tdi_sync[SYNC_STAGES-1];
  assign rise  = tck_s & ~tck_prev;
  assign fall  = ~tck_s & tck_prev;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= TLR;
    else        state_q <= state_d;
  end

  // IEEE 1149.1 next-state, advanced only on a synchronised tck rise
  always_comb begin
    state_d = state_q;
    if (rise) begin
      case (state_q)
        TLR:     state_d = tms_s ? TLR    : RTI;
        RTI:     state_d = tms_s ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = tms_s ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = tms_s ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = tms_s ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = tms_s ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  assign tap_state = state_q;

  // Unrecognised instruction codes fall through to BYPASS
  assign sel_user   = (ir_q == IR_USER);
  assign sel_idcode = (ir_q == IR_IDCODE);
  assign dr_bit0    = sel_user ? user_sr[0] : (sel_idcode ? idcode_sr[0] : bypass_sr);

  // Capture/shift on rise, drive tdo and update on fall; rise wins if both appear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q         <= IR_IDCODE;
      ir_sr        <= '0;
      bypass_sr    <= 1'b0;
      idcode_sr    <= '0;
      user_sr      <= '0;
      user_dr      <= '0;
      tdo          <= 1'b0;
      tdo_oe       <= 1'b0;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= 1'b0;
      if (rise) begin
        case (state_q)
          CAP_IR: ir_sr <= IR_LEN'(2'b01);
          SH_IR:  ir_sr <= {tdi_s, ir_sr[IR_LEN-1:1]};
          CAP_DR: begin
            if (sel_user)        user_sr   <= user_dr_in;
            else if (sel_idcode) idcode_sr <= IDCODE_VAL;
            else                 bypass_sr <= 1'b0;
          end
          SH_DR: begin
            if (sel_user)        user_sr   <= (user_sr >> 1) | (DR_WIDTH'(tdi_s) << (DR_WIDTH - 1));
            else if (sel_idcode) idcode_sr <= {tdi_s, idcode_sr[ID_W-1:1]};
            else                 bypass_sr <= tdi_s;
          end
          default: ;
        endcase
      end else if (fall) begin
        tdo_oe <= (state_q == SH_DR) || (state_q == SH_IR);
        if (state_q == SH_IR)      tdo <= ir_sr[0];
        else if (state_q == SH_DR) tdo <= dr_bit0;
        if (state_q == UPD_IR) ir_q <= ir_sr;
        if (state_q == UPD_DR && sel_user) begin
          user_dr      <= user_sr;
          update_pulse <= 1'b1;
        end
      end
      if (state_q == TLR) ir_q <= IR_IDCODE;
    end
  end

endmodule

// File: tb/tb_jtag_tap_param.sv
// Directed bench for jtag_tap_param: tck toggles every 8 clk; tdo is sampled just
// before each tck rise, i.e. the value launched on the previous fall.
module tb_jtag_tap_param;

  localparam int IR_LEN = 4;
  localparam int DR_W   = 8;
  localparam logic [31:0] IDCODE = 32'h1000_563F;

  logic            clk = 1'b0;
  logic            rst_n, tck, tms, tdi;
  logic            tdo, tdo_oe, update_pulse;
  logic [DR_W-1:0] user_dr, user_dr_in;
  logic [3:0]      tap_state;

  int n_cmp = 0;
  int n_bad = 0;
  int pulse_total = 0;

  always #5 clk = ~clk;

  jtag_tap_param #(
    .IR_LEN(4), .DR_WIDTH(8), .IDCODE_VAL(32'h1000_563F), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .user_dr(user_dr), .user_dr_in(user_dr_in),
    .update_pulse(update_pulse), .tap_state(tap_state)
  );

  always @(negedge clk) if (update_pulse === 1'b1) pulse_total++;

  typedef struct {
    logic [3:0]  ir;
    logic [7:0]  uin;
    int          n;
    logic [31:0] din;
    logic [31:0] dexp;
    logic [7:0]  uexp;
    int          pexp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clock_bit(input logic tms_v, input logic tdi_v, output logic tdo_s, output logic oe_s);
    tms = tms_v;
    tdi = tdi_v;
    repeat (8) @(negedge clk);
    tdo_s = tdo;
    oe_s  = tdo_oe;
    tck = 1'b1;
    repeat (8) @(negedge clk);
    tck = 1'b0;
  endtask

  task automatic step(input logic tms_v);
    logic a, b;
    clock_bit(tms_v, 1'b0, a, b);
  endtask

  // From RTI: load an IR code, return the captured IR bits, end in RTI
  task automatic load_ir(input logic [3:0] code, output logic [3:0] cap);
    logic o, e;
    cap = '0;
    step(1); step(1); step(0); step(0);
    for (int i = 0; i < IR_LEN; i++) begin
      clock_bit(i == IR_LEN - 1, code[i], o, e);
      cap[i] = o;
    end
    step(1); step(0);
  endtask

  // From RTI: shift n DR bits LSB-first, return tdo bits, end in RTI
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] dout, output logic oe_all);
    logic o, e;
    step(1); step(0); step(0);
    dout   = '0;
    oe_all = 1'b1;
    for (int i = 0; i < n; i++) begin
      clock_bit(i == n - 1, din[i], o, e);
      dout[i] = o;
      oe_all  = oe_all & e;
    end
    step(1); step(0);
  endtask

  initial begin
    logic [31:0] dout;
    logic        oe_all, o, e;
    logic [3:0]  cap;
    int          p0;

    rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0; user_dr_in = '0;

    tbl[0] = '{4'b0001, 8'h00, 32, 32'h0,   IDCODE,    8'h00, 0};
    tbl[1] = '{4'b1111, 8'h00, 4,  32'hD,   32'hA,     8'h00, 0};
    tbl[2] = '{4'b0010, 8'h3C, 8,  32'hA5,  32'h3C,    8'hA5, 1};
    tbl[3] = '{4'b0101, 8'h00, 4,  32'hD,   32'hA,     8'hA5, 0};
    tbl[4] = '{4'b1111, 8'h00, 8,  32'h96,  32'h2C,    8'hA5, 0};
    tbl[5] = '{4'b0010, 8'h81, 12, 32'h5A3, 32'h381,   8'h5A, 1};
    tbl[6] = '{4'b0011, 8'h00, 1,  32'h1,   32'h0,     8'h5A, 0};
    tbl[7] = '{4'b0010, 8'hF0, 8,  32'h0F,  32'hF0,    8'h0F, 1};

    repeat (4) @(negedge clk);
    check("rst_state",  32'(tap_state),    32'hF);
    check("rst_oe",     32'(tdo_oe),       32'h0);
    check("rst_tdo",    32'(tdo),          32'h0);
    check("rst_userdr", 32'(user_dr),      32'h0);
    check("rst_pulse",  32'(update_pulse), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default IR after reset is IDCODE
    step(0);
    shift_dr(32, 32'h0, dout, oe_all);
    check("idcode_default", dout, IDCODE);
    check("idcode_oe", 32'(oe_all), 32'h1);

    for (int k = 0; k < 8; k++) begin
      user_dr_in = tbl[k].uin;
      load_ir(tbl[k].ir, cap);
      check($sformatf("v%0d_ircap", k), 32'(cap), 32'h1);
      p0 = pulse_total;
      shift_dr(tbl[k].n, tbl[k].din, dout, oe_all);
      check($sformatf("v%0d_tdo", k), dout, tbl[k].dexp);
      check($sformatf("v%0d_oe_shift", k), 32'(oe_all), 32'h1);
      check($sformatf("v%0d_userdr", k), 32'(user_dr), 32'(tbl[k].uexp));
      check($sformatf("v%0d_pulses", k), 32'(pulse_total - p0), 32'(tbl[k].pexp));
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_oe_idle", k), 32'(tdo_oe), 32'h0);
      check($sformatf("v%0d_state", k), 32'(tap_state), 32'hC);
    end

    // TMS high x5 from Shift-DR under USER: passes Update-DR (one shift of tdi=1 first)
    user_dr_in = 8'h81;
    load_ir(4'b0010, cap);
    check("t4_ircap", 32'(cap), 32'h1);
    p0 = pulse_total;
    step(1); step(0); step(0);
    check("t4_in_shdr", 32'(tap_state), 32'h2);
    for (int i = 0; i < 5; i++) clock_bit(1'b1, 1'b1, o, e);
    check("t4_tlr", 32'(tap_state), 32'hF);
    check("t4_userdr", 32'(user_dr), 32'hC0);
    check("t4_pulses", 32'(pulse_total - p0), 32'h1);
    repeat (20) @(negedge clk);
    check("t4_userdr_hold", 32'(user_dr), 32'hC0);
    step(0);
    shift_dr(32, 32'h0, dout, oe_all);
    check("t4_idcode", dout, IDCODE);

    // Reset pulse in the middle of a USER shift
    user_dr_in = 8'h55;
    load_ir(4'b0010, cap);
    step(1); step(0); step(0);
    for (int i = 0; i < 3; i++) clock_bit(1'b0, 1'b1, o, e);
    check("t5_oe_before", 32'(tdo_oe), 32'h1);
    p0 = pulse_total;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_state", 32'(tap_state), 32'hF);
    check("t5_oe", 32'(tdo_oe), 32'h0);
    check("t5_userdr", 32'(user_dr), 32'h0);
    repeat (20) @(negedge clk);
    check("t5_pulses", 32'(pulse_total - p0), 32'h0);
    step(0);
    shift_dr(32, 32'h0, dout, oe_all);
    check("t5_idcode", dout, IDCODE);
    check("t5_userdr_after", 32'(user_dr), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
